// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: issues in-order imem reads from fetch_pc and buffers returned words
// in a prefetch FIFO for decode. Redirects flush the FIFO and drop in-flight responses.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc,
  output logic [31:0] insn
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] live;
  logic [CW:0]   used;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_insn [DEPTH];
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every output of an always_comb block is assigned on every path, so no latch is inferred.
  always_comb begin
    live      = inflight - drop_cnt;
    used      = {1'b0, count} + {1'b0, live};
    target_pc = redirect_pc & 32'hFFFF_FFFC;
    imem_req  = !reset && !redirect && (used < {1'b0, DEPTH_C});
    imem_addr = fetch_pc;
    accept    = imem_req && imem_gnt;
    // Responses with nothing outstanding are stray and ignored entirely.
    resp      = imem_rvalid && (inflight != '0);
    push      = resp && (drop_cnt == '0);
    out_valid = !reset && (count != '0);
    pop       = out_valid && out_ready;
    pc        = out_valid ? fifo_pc[rd_ptr]   : 32'h0;
    insn      = out_valid ? fifo_insn[rd_ptr] : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old path and must be discarded on return.
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(resp);
      drop_cnt <= inflight - CW'(resp);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(accept) - CW'(resp);
      if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - ONE_C;
      if (push) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; occupancy gates every read, so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (push && !redirect && !reset) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_insn[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: an in-order memory model with programmable latency and a
// monitor that records every word accepted by decode.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8002_0000;
  localparam int          DEPTH    = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_gnt;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] insn;

  mips_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_gnt    (imem_gnt),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pc          (pc),
    .insn        (insn)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; int cyc; } out_t;

  req_t pend[$];
  out_t mon[$];
  int   cyc      = 0;
  int   mem_lat  = 1;
  int   acc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;
  int   c0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    tick(2);
  endtask

  task automatic release_reset();
    mon.delete();
    acc_cnt = 0;
    reset   = 1'b0;
  endtask

  // Memory model and decode-side monitor, both sampled at the active edge.
  always @(posedge clock) begin
    if (reset) begin
      pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req && imem_gnt) begin
        pend.push_back('{imem_addr, cyc + mem_lat});
        acc_cnt++;
      end
      if (out_valid && out_ready && !redirect) mon.push_back('{pc, insn, cyc});
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_lat = 1;
    tick(2);
    check("rst_req",   imem_req,  0);
    check("rst_valid", out_valid, 0);
    check("rst_pc",    pc,        0);
    check("rst_insn",  insn,      0);

    // Streaming fetch, latency 1, decode always ready.
    imem_gnt = 1'b1; out_ready = 1'b1;
    release_reset();
    c0 = cyc;
    #1;
    check("t1_req0",  imem_req,  1);
    check("t1_addr0", imem_addr, RESET_PC);
    tick(1);
    check("t1_addr1",  imem_addr, RESET_PC + 32'd4);
    check("t1_valid1", out_valid, 0);
    tick(1);
    check("t1_addr2",  imem_addr, RESET_PC + 32'd8);
    check("t1_valid2", out_valid, 1);
    check("t1_head",   pc,        RESET_PC);
    tick(6);
    check("t1_mon_n", mon.size() >= 3, 1);
    check("t1_first_cyc", mon[0].cyc, c0 + 2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_pc%0d", i),   mon[i].pc,   RESET_PC + 32'(4 * i));
      check($sformatf("t1_insn%0d", i), mon[i].insn, mem_word(RESET_PC + 32'(4 * i)));
      if (i > 0) check($sformatf("t1_cyc%0d", i), mon[i].cyc, mon[i-1].cyc + 1);
    end

    // Decode stalled: credit limit caps outstanding work at DEPTH.
    apply_reset();
    mem_lat = 1; imem_gnt = 1'b1; out_ready = 1'b0;
    release_reset();
    tick(12);
    check("t2_accepts", acc_cnt,   DEPTH);
    check("t2_req_off", imem_req,  0);
    check("t2_count",   dut.count, DEPTH);
    out_ready = 1'b1;
    tick(10);
    check("t2_mon_n", mon.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_pc%0d", i), mon[i].pc, RESET_PC + 32'(4 * i));
    check("t2_insn3", mon[3].insn, mem_word(RESET_PC + 32'd12));

    // Latency 3, redirect with two words outstanding.
    apply_reset();
    mem_lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
    release_reset();
    tick(2);
    imem_gnt = 1'b0;
    check("t3_inflight", dut.inflight, 2);
    redirect = 1'b1; redirect_pc = 32'h8002_0100;
    #1;
    check("t3_req_redir", imem_req, 0);
    tick(1);
    redirect = 1'b0; imem_gnt = 1'b1;
    #1;
    check("t3_drop", dut.drop_cnt, 2);
    check("t3_addr", imem_addr,    32'h8002_0100);
    tick(10);
    check("t3_mon_n", mon.size() >= 1, 1);
    check("t3_pc",    mon[0].pc,   32'h8002_0100);
    check("t3_insn",  mon[0].insn, mem_word(32'h8002_0100));

    // Redirect in the same cycle as a decode handshake and an arriving response.
    apply_reset();
    mem_lat = 2; imem_gnt = 1'b1; out_ready = 1'b1;
    release_reset();
    tick(8);
    check("t4_rvalid",   imem_rvalid,  1);
    check("t4_valid",    out_valid,    1);
    check("t4_inflight", dut.inflight, 2);
    redirect = 1'b1; redirect_pc = 32'h8002_0200;
    mon.delete();
    #1;
    check("t4_req_redir", imem_req, 0);
    tick(1);
    redirect = 1'b0;
    #1;
    check("t4_valid_next", out_valid,    0);
    check("t4_count",      dut.count,    0);
    check("t4_drop",       dut.drop_cnt, 1);
    tick(1);
    check("t4_valid_next2", out_valid, 0);
    tick(8);
    check("t4_mon_n", mon.size() >= 1, 1);
    check("t4_pc",    mon[0].pc,   32'h8002_0200);
    check("t4_insn",  mon[0].insn, mem_word(32'h8002_0200));

    // Misaligned redirect target and address wrap.
    redirect = 1'b1; redirect_pc = 32'h8002_0102;
    tick(1);
    redirect = 1'b0;
    #1;
    check("t5_align", imem_addr, 32'h8002_0100);
    mem_lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    mon.delete();
    tick(1);
    redirect = 1'b0;
    #1;
    check("t5_req",  imem_req,  1);
    check("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick(1);
    check("t5_wrap", imem_addr, 32'h0);
    tick(8);
    check("t5_mon_n",  mon.size() >= 2, 1);
    check("t5_pc0",    mon[0].pc,   32'hFFFF_FFFC);
    check("t5_pc1",    mon[1].pc,   32'h0);
    check("t5_insn1",  mon[1].insn, mem_word(32'h0));

    // Reset with buffered and outstanding words, overriding a simultaneous redirect.
    apply_reset();
    mem_lat = 3; imem_gnt = 1'b1; out_ready = 1'b0;
    release_reset();
    tick(5);
    check("t6_count_pre",    dut.count,    2);
    check("t6_inflight_pre", dut.inflight, 2);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h8002_0300;
    #1;
    check("t6_req_rst",   imem_req,  0);
    check("t6_valid_rst", out_valid, 0);
    check("t6_insn_rst",  insn,      0);
    tick(1);
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    mon.delete();
    #1;
    check("t6_valid",    out_valid,    0);
    check("t6_insn",     insn,         0);
    check("t6_addr",     imem_addr,    RESET_PC);
    check("t6_inflight", dut.inflight, 0);
    check("t6_drop",     dut.drop_cnt, 0);
    check("t6_count",    dut.count,    0);
    tick(8);
    check("t6_mon_n", mon.size() >= 1, 1);
    check("t6_pc",    mon[0].pc,   RESET_PC);
    check("t6_insn0", mon[0].insn, mem_word(RESET_PC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
